// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
//   state_t        : handshake FSM states
//   booth_digit_t  : recoded radix-4 Booth digit
//   iter_count()   : number of recoding steps for a given operand width
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    // Operands are extended by two bits, so (WIDTH+2)/2 digits cover them.
    function automatic int iter_count(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder (combinational).
//   triplet : {r[2i+1], r[2i], r[2i-1]}
//   digit   : recoded digit in {-2, -1, 0, +1, +2}
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);

    always_comb begin
        digit = ZERO;
        case (triplet)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_mult_seq.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes.
// One operation in flight; each product is held until the consumer takes it.
//   clk, reset_n                       : clock, async active-low reset
//   in_valid/in_ready                  : operand handshake
//   in_signed, in_m, in_r, in_tag      : mode, multiplicand, multiplier, tag
//   out_valid/out_ready                : product handshake
//   out_prod, out_tag                  : product (2*WIDTH bits) and its tag
module booth_r4_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_r,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int W2    = WIDTH + 2;
    localparam int AW    = 2 * W2;
    localparam int ITER  = iter_count(WIDTH);
    localparam int CNT_W = $clog2(ITER + 1);

    state_t                state;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  mcand;    // multiplicand, pre-shifted by 2i
    logic [W2-1:0]         mplier;   // multiplier, consumed two bits per step
    logic                  r_prev;   // r[2i-1] of the current triplet
    logic [CNT_W-1:0]      cnt;
    logic [TAG_W-1:0]      tag_q;

    logic [W2-1:0]         m_ext;
    logic [W2-1:0]         r_ext;
    logic                  accept;
    booth_digit_t          digit;
    logic signed [AW-1:0]  addend;

    // in_ready depends on state and out_ready only, never on in_valid.
    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    // Two extra bits make an unsigned operand a non-negative signed value.
    assign m_ext = in_signed ? {{2{in_m[WIDTH-1]}}, in_m} : {2'b00, in_m};
    assign r_ext = in_signed ? {{2{in_r[WIDTH-1]}}, in_r} : {2'b00, in_r};

    booth_r4_encoder u_enc (
        .triplet ({mplier[1:0], r_prev}),
        .digit   (digit)
    );

    always_comb begin
        addend = '0;
        case (digit)
            POS1:    addend = mcand;
            POS2:    addend = mcand <<< 1;
            NEG1:    addend = -mcand;
            NEG2:    addend = -(mcand <<< 1);
            default: addend = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            r_prev    <= 1'b0;
            cnt       <= '0;
            tag_q     <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_tag   <= '0;
        end else if (accept) begin
            // Covers both IDLE and the no-bubble DONE->RUN hand-over.
            state     <= RUN;
            acc       <= '0;
            mcand     <= {{W2{m_ext[W2-1]}}, m_ext};
            mplier    <= r_ext;
            r_prev    <= 1'b0;
            cnt       <= '0;
            tag_q     <= in_tag;
            out_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (cnt == CNT_W'(ITER)) begin
                        // Low 2*WIDTH bits are exact in both modes.
                        out_prod  <= acc[2*WIDTH-1:0];
                        out_tag   <= tag_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc    <= acc + addend;
                        mcand  <= mcand <<< 2;
                        mplier <= {2'b00, mplier[W2-1:2]};
                        r_prev <= mplier[1];
                        cnt    <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
module tb_booth_r4_mult_seq;

    localparam int LAT    = 18;   // accept edge -> out_valid, WIDTH=32
    localparam int PERIOD = 19;   // LAT plus the single DONE cycle

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [31:0] in_m = '0;
    logic [31:0] in_r = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_prod;
    logic [3:0]  out_tag;

    typedef struct {
        logic [63:0] prod;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_r4_mult_seq #(.WIDTH(32), .TAG_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_m      (in_m),
        .in_r      (in_r),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", name, obs, exp);
        end
    endtask

    // Reference product: extend to 64 bits, keep the low 64 bits.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] m, input logic [31:0] r);
        logic [63:0] a;
        logic [63:0] b;
        a = sgn ? {{32{m[31]}}, m} : {32'b0, m};
        b = sgn ? {{32{r[31]}}, r} : {32'b0, r};
        return a * b;
    endfunction

    task automatic drive(input logic sgn, input logic [31:0] m, input logic [31:0] r, input logic [3:0] tag);
        in_signed = sgn;
        in_m      = m;
        in_r      = r;
        in_tag    = tag;
        in_valid  = 1'b1;
    endtask

    // Called #1 after an edge with a beat presented and in_ready expected high.
    task automatic accept_now(input string name, input logic [63:0] exp, input logic [3:0] tag);
        exp_t e;
        chk({name, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        e.prod = exp;
        e.tag  = tag;
        sb.push_back(e);
        #1;
    endtask

    task automatic wait_out(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, lat, LAT);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        chk({name, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({name, "_prod"}, out_prod, e.prod);
            chk({name, "_tag"}, out_tag, e.tag);
        end
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [31:0] m,
                          input logic [31:0] r, input logic [3:0] tag, input logic [63:0] exp);
        int lat;
        drive(sgn, m, r, tag);
        accept_now(name, exp, tag);
        in_valid = 1'b0;
        // Change operands after accept; they must be ignored.
        in_m = ~m;
        in_r = ~r;
        in_signed = ~sgn;
        in_tag = ~tag;
        wait_out(name, lat);
        check_out(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        int          seen;
        int          last_rise;
        logic [63:0] held_prod;
        logic [3:0]  held_tag;
        logic [31:0] rm;
        logic [31:0] rr;
        logic        rs;
        logic [31:0] bm[4];
        logic [31:0] br[4];
        logic        bs[4];

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_prod", out_prod, 64'h0);
        chk("rst_out_tag", out_tag, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Directed products
        run_op("s_m3x7", 1'b1, 32'hFFFF_FFFD, 32'd7, 4'h5, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h1, 64'hFFFF_FFFE_0000_0001);
        run_op("s_max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2, 64'h0000_0000_0000_0001);
        run_op("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 4'h3, 64'h4000_0000_0000_0000);
        run_op("s_minx1", 1'b1, 32'h8000_0000, 32'd1, 4'h4, 64'hFFFF_FFFF_8000_0000);
        run_op("u_zero", 1'b0, 32'h0, 32'h1234_5678, 4'h6, 64'h0);
        run_op("u_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 4'h7, 64'h4000_0000_0000_0000);

        for (int i = 0; i < 6; i++) begin
            rm = $urandom;
            rr = $urandom;
            rs = 1'(i % 2);
            run_op("rand", rs, rm, rr, 4'(8 + i), model(rs, rm, rr));
        end

        // Backpressure: hold in DONE for 10 cycles with a new beat waiting
        out_ready = 1'b0;
        drive(1'b1, 32'hFFFF_FFFB, 32'd12345, 4'h9);
        accept_now("bp_first", model(1'b1, 32'hFFFF_FFFB, 32'd12345), 4'h9);
        drive(1'b0, 32'hDEAD_BEEF, 32'h0000_1000, 4'hA);
        wait_out("bp_first", lat);
        check_out("bp_first");
        held_prod = model(1'b1, 32'hFFFF_FFFB, 32'd12345);
        held_tag  = 4'h9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_prod", out_prod, held_prod);
            chk("bp_hold_tag", out_tag, held_tag);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        accept_now("bp_second", model(1'b0, 32'hDEAD_BEEF, 32'h0000_1000), 4'hA);
        in_valid = 1'b0;
        chk("bp_release_valid", out_valid, 1'b0);
        wait_out("bp_second", lat);
        check_out("bp_second");
        @(posedge clk);
        #1;

        // Back-to-back: four ops, in_valid and out_ready held high
        bm = '{32'd3, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'hABCD_0123};
        br = '{32'd5, 32'd100, 32'h7FFF_FFFF, 32'hFEDC_BA98};
        bs = '{1'b0, 1'b1, 1'b1, 1'b0};
        last_rise = 0;
        drive(bs[0], bm[0], br[0], 4'd0);
        accept_now("b2b", model(bs[0], bm[0], br[0]), 4'd0);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) drive(bs[i], bm[i], br[i], 4'(i));
            else in_valid = 1'b0;
            wait_out("b2b", lat);
            check_out("b2b");
            if (i > 1) chk("b2b_spacing", cyc - last_rise, PERIOD);
            last_rise = cyc;
            if (i < 4) accept_now("b2b", model(bs[i], bm[i], br[i]), 4'(i));
            else begin
                @(posedge clk);
                #1;
            end
        end

        // Reset at RUN step 5
        drive(1'b1, 32'h0000_0042, 32'hFFFF_FF00, 4'hC);
        accept_now("rst_run", 64'h0, 4'hC);
        in_valid = 1'b0;
        void'(sb.pop_front());
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_run_out_valid", out_valid, 1'b0);
        chk("rst_run_in_ready", in_ready, 1'b1);
        chk("rst_run_out_prod", out_prod, 64'h0);
        chk("rst_run_out_tag", out_tag, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_run_release_in_ready", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("rst_run_no_stale", seen, 0);
        run_op("rst_run_next", 1'b1, 32'h0000_0042, 32'hFFFF_FF00, 4'hD,
               model(1'b1, 32'h0000_0042, 32'hFFFF_FF00));

        // Reset while a product is held in DONE
        out_ready = 1'b0;
        drive(1'b0, 32'd1000, 32'd1000, 4'hE);
        accept_now("rst_done", 64'd1_000_000, 4'hE);
        in_valid = 1'b0;
        wait_out("rst_done", lat);
        check_out("rst_done");
        reset_n = 1'b0;
        #1;
        chk("rst_done_out_valid", out_valid, 1'b0);
        chk("rst_done_out_prod", out_prod, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_done_in_ready", in_ready, 1'b1);
        run_op("final", 1'b1, 32'h8000_0001, 32'hFFFF_FFFF,
               4'hF, model(1'b1, 32'h8000_0001, 32'hFFFF_FFFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
